// File: rtl/ex_stage_pkg.sv
// Shared types for the execute stage: the ID->EX decode bus, the EX->IO and EX->ID
// bundles, and the one-hot ALU operation indices.
package ex_stage_pkg;

  localparam int unsigned ALU_OP_ADD   = 0;
  localparam int unsigned ALU_OP_SUB   = 1;
  localparam int unsigned ALU_OP_SLT   = 2;
  localparam int unsigned ALU_OP_SLTU  = 3;
  localparam int unsigned ALU_OP_AND   = 4;
  localparam int unsigned ALU_OP_NOR   = 5;
  localparam int unsigned ALU_OP_OR    = 6;
  localparam int unsigned ALU_OP_XOR   = 7;
  localparam int unsigned ALU_OP_SLL   = 8;
  localparam int unsigned ALU_OP_SRL   = 9;
  localparam int unsigned ALU_OP_SRA   = 10;
  localparam int unsigned ALU_OP_LUI   = 11;
  localparam int unsigned ALU_OP_WIDTH = 12;

  typedef struct packed {
    logic        valid;
    logic [31:0] program_count;
    logic [31:0] source_register_value;
    logic [31:0] multi_use_register_value;
    logic [15:0] immediate;
    logic [4:0]  write_register;
    logic        source1_is_shift_amount;
    logic        source1_is_program_count;
    logic        source2_is_8;
    logic        source2_is_immediate;
    logic        is_load_operation;
    logic        memory_write;
    logic        register_write;
    logic [ALU_OP_WIDTH-1:0] alu_operation;
  } id_to_ex_decode_bus_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] program_count;
    logic        is_load;
    logic        register_write;
    logic [4:0]  write_register;
    logic [31:0] alu_result;
  } ex_to_io_bus_t;

  typedef struct packed {
    logic        valid;
    logic        data_valid;
    logic [4:0]  write_register;
    logic [31:0] write_data;
  } ex_to_id_back_pass_bus_t;

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational 32-bit ALU driven by a one-hot operation vector; no bit set yields zero.
module ex_stage_alu
  import ex_stage_pkg::*;
(
  input  logic [11:0] alu_operation,
  input  logic [31:0] source1,
  input  logic [31:0] source2,
  output logic [31:0] result
);

  logic [4:0] shift_amount;

  // AND-OR selection: with a one-hot operation exactly one term survives.
  always_comb begin
    shift_amount = source1[4:0];
    result = '0;
    if (alu_operation[ALU_OP_ADD])  result |= source1 + source2;
    if (alu_operation[ALU_OP_SUB])  result |= source1 - source2;
    if (alu_operation[ALU_OP_SLT])  result |= {31'b0, $signed(source1) < $signed(source2)};
    if (alu_operation[ALU_OP_SLTU]) result |= {31'b0, source1 < source2};
    if (alu_operation[ALU_OP_AND])  result |= source1 & source2;
    if (alu_operation[ALU_OP_NOR])  result |= ~(source1 | source2);
    if (alu_operation[ALU_OP_OR])   result |= source1 | source2;
    if (alu_operation[ALU_OP_XOR])  result |= source1 ^ source2;
    if (alu_operation[ALU_OP_SLL])  result |= source2 << shift_amount;
    if (alu_operation[ALU_OP_SRL])  result |= source2 >> shift_amount;
    if (alu_operation[ALU_OP_SRA])  result |= $unsigned($signed(source2) >>> shift_amount);
    if (alu_operation[ALU_OP_LUI])  result |= {source2[15:0], 16'b0};
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: latches the ID decode bus, runs the ALU, issues the lw/sw data-SRAM
// request and hands results to IO and back to ID for forwarding/interlock.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         io_allow_in,
  output logic         ex_allow_in,
  input  logic [136:0] id_to_ex_decode_bus,
  output logic [71:0]  ex_to_io_bus,
  output logic [38:0]  ex_to_id_back_pass_bus,
  output logic         data_sram_request,
  output logic         data_sram_write,
  output logic [3:0]   data_sram_byte_enable,
  output logic [31:0]  data_sram_address,
  output logic [31:0]  data_sram_write_data,
  input  logic         data_sram_address_ok
);

  id_to_ex_decode_bus_t    in_bus;
  id_to_ex_decode_bus_t    payload_q, payload_d;
  logic                    ex_valid_q, ex_valid_d;
  logic                    request_accepted_q, request_accepted_d;
  logic                    is_mem, ex_ready_go, ex_leave;
  logic [31:0]             source1, source2, alu_result;
  ex_to_io_bus_t           to_io;
  ex_to_id_back_pass_bus_t back_pass;
  logic                    unused_payload_valid;

  ex_stage_alu u_alu (
    .alu_operation (payload_q.alu_operation),
    .source1       (source1),
    .source2       (source2),
    .result        (alu_result)
  );

  always_comb begin
    in_bus = id_to_ex_decode_bus;
    unused_payload_valid = payload_q.valid;

    source1 = payload_q.source1_is_shift_amount  ? {27'b0, payload_q.immediate[10:6]} :
              payload_q.source1_is_program_count ? payload_q.program_count :
                                                   payload_q.source_register_value;
    source2 = payload_q.source2_is_8         ? 32'd8 :
              payload_q.source2_is_immediate ? {{16{payload_q.immediate[15]}}, payload_q.immediate} :
                                               payload_q.multi_use_register_value;

    // request_accepted suppresses a second request while the accepted lw/sw waits on IO.
    is_mem            = payload_q.is_load_operation | payload_q.memory_write;
    data_sram_request = ex_valid_q & is_mem & ~request_accepted_q;
    ex_ready_go       = ~is_mem | request_accepted_q | (data_sram_request & data_sram_address_ok);
    ex_allow_in       = ~ex_valid_q | (ex_ready_go & io_allow_in);
    ex_leave          = ex_valid_q & ex_ready_go & io_allow_in;

    ex_valid_d = ex_valid_q;
    if (ex_allow_in) ex_valid_d = in_bus.valid;
    if (reset)       ex_valid_d = 1'b0;

    payload_d = payload_q;
    if (in_bus.valid && ex_allow_in) payload_d = in_bus;

    request_accepted_d = request_accepted_q;
    if (ex_leave) request_accepted_d = 1'b0;
    else if (data_sram_request && data_sram_address_ok && !io_allow_in) request_accepted_d = 1'b1;
    if (reset) request_accepted_d = 1'b0;

    data_sram_write       = payload_q.memory_write;
    data_sram_byte_enable = payload_q.memory_write ? 4'hf : 4'h0;
    data_sram_address     = alu_result;
    data_sram_write_data  = payload_q.multi_use_register_value;

    to_io.valid          = ex_valid_q & ex_ready_go;
    to_io.program_count  = payload_q.program_count;
    to_io.is_load        = payload_q.is_load_operation;
    to_io.register_write = payload_q.register_write;
    to_io.write_register = payload_q.write_register;
    to_io.alu_result     = alu_result;
    ex_to_io_bus         = to_io;

    back_pass.valid          = ex_valid_q & payload_q.register_write & (payload_q.write_register != 5'd0);
    back_pass.data_valid     = ~payload_q.is_load_operation;
    back_pass.write_register = payload_q.write_register;
    back_pass.write_data     = alu_result;
    ex_to_id_back_pass_bus   = back_pass;
  end

  always_ff @(posedge clock) begin
    ex_valid_q         <= ex_valid_d;
    request_accepted_q <= request_accepted_d;
    payload_q          <= payload_d;
  end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed pipeline scenarios followed by randomized traffic, all
// checked against a transaction-level model of the stage.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    io_allow_in;
  logic                    ex_allow_in;
  id_to_ex_decode_bus_t    dec;
  ex_to_io_bus_t           io_bus;
  ex_to_id_back_pass_bus_t bp;
  logic                    req, wr, aok;
  logic [3:0]              be;
  logic [31:0]             addr, wdata;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model state: the instruction held in EX and how many requests it has had accepted.
  id_to_ex_decode_bus_t held[$];
  int unsigned          granted = 0;
  logic                 m_occ, m_req, m_done, m_allow;
  id_to_ex_decode_bus_t base, d;

  always #5 clock = ~clock;

  ex_stage dut (
    .clock                  (clock),
    .reset                  (reset),
    .io_allow_in            (io_allow_in),
    .ex_allow_in            (ex_allow_in),
    .id_to_ex_decode_bus    (dec),
    .ex_to_io_bus           (io_bus),
    .ex_to_id_back_pass_bus (bp),
    .data_sram_request      (req),
    .data_sram_write        (wr),
    .data_sram_byte_enable  (be),
    .data_sram_address      (addr),
    .data_sram_write_data   (wdata),
    .data_sram_address_ok   (aok)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input id_to_ex_decode_bus_t x);
    logic [31:0] a, b;
    int unsigned sh;
    int k;
    a = x.source1_is_shift_amount  ? {27'd0, x.immediate[10:6]} :
        x.source1_is_program_count ? x.program_count : x.source_register_value;
    b = x.source2_is_8         ? 32'd8 :
        x.source2_is_immediate ? {{16{x.immediate[15]}}, x.immediate} : x.multi_use_register_value;
    sh = a % 32;
    k = -1;
    for (int unsigned i = 0; i < 12; i++) if (x.alu_operation[i]) k = int'(i);
    case (k)
      0:  return a + b;
      1:  return a - b;
      2:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      3:  return (a < b) ? 32'd1 : 32'd0;
      4:  return a & b;
      5:  return ~(a | b);
      6:  return a | b;
      7:  return a ^ b;
      8:  return b << sh;
      9:  return b >> sh;
      10: return (b >> sh) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      11: return b * 32'd65536;
      default: return 32'd0;
    endcase
  endfunction

  function automatic id_to_ex_decode_bus_t rand_dec();
    id_to_ex_decode_bus_t x;
    int unsigned k, m;
    x = '0;
    x.valid                    = $urandom_range(9) < 7;
    x.program_count            = $urandom & 32'hFFFF_FFFC;
    x.source_register_value    = ($urandom_range(3) == 0) ? 32'($urandom_range(7)) - 32'd4 : $urandom;
    x.multi_use_register_value = ($urandom_range(3) == 0) ? 32'($urandom_range(7)) - 32'd4 : $urandom;
    x.immediate                = 16'($urandom);
    x.write_register           = 5'($urandom_range(31));
    x.register_write           = 1'($urandom_range(1));
    x.source1_is_shift_amount  = $urandom_range(3) == 0;
    x.source1_is_program_count = $urandom_range(5) == 0;
    x.source2_is_8             = $urandom_range(7) == 0;
    x.source2_is_immediate     = $urandom_range(2) == 0;
    k = $urandom_range(12);
    x.alu_operation = (k < 12) ? (12'b1 << k) : 12'b0;
    m = $urandom_range(5);
    x.is_load_operation = (m == 0);
    x.memory_write      = (m == 1);
    return x;
  endfunction

  // Apply inputs, then compare every output at the falling edge.
  task automatic drive(input logic rst, input id_to_ex_decode_bus_t x, input logic ioa, input logic ok);
    id_to_ex_decode_bus_t h;
    logic mem;
    logic [31:0] res;
    reset = rst; dec = x; io_allow_in = ioa; aok = ok;
    m_occ   = held.size() > 0;
    h       = m_occ ? held[0] : '0;
    mem     = m_occ && (h.is_load_operation || h.memory_write);
    m_req   = mem && (granted == 0);
    m_done  = !mem || (granted > 0) || (m_req && ok);
    m_allow = !m_occ || (m_done && ioa);
    @(negedge clock);
    check_eq("allow_in", 32'(ex_allow_in), 32'(m_allow));
    check_eq("io_valid", 32'(io_bus.valid), 32'(m_occ && m_done));
    check_eq("sram_req", 32'(req), 32'(m_req));
    check_eq("bp_valid", 32'(bp.valid), 32'(m_occ && h.register_write && (h.write_register != 5'd0)));
    if (m_occ) begin
      res = ref_result(h);
      check_eq("io_pc", io_bus.program_count, h.program_count);
      check_eq("io_result", io_bus.alu_result, res);
      check_eq("io_wreg", 32'(io_bus.write_register), 32'(h.write_register));
      check_eq("io_flags", 32'({io_bus.is_load, io_bus.register_write}),
               32'({h.is_load_operation, h.register_write}));
      check_eq("bp_data_valid", 32'(bp.data_valid), 32'(!h.is_load_operation));
      check_eq("bp_data", bp.write_data, res);
      if (mem) begin
        check_eq("sram_addr", addr, res);
        check_eq("sram_write", 32'(wr), 32'(h.memory_write));
        check_eq("sram_be", 32'(be), h.memory_write ? 32'hF : 32'h0);
        check_eq("sram_wdata", wdata, h.multi_use_register_value);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) begin
      held.delete();
      granted = 0;
    end else begin
      if (m_req && aok) granted++;
      if (m_occ && m_done && io_allow_in) begin
        if (held[0].is_load_operation || held[0].memory_write)
          check_eq("one_request", 32'(granted), 32'd1);
        void'(held.pop_front());
        granted = 0;
      end
      if (m_allow && dec.valid) held.push_back(dec);
    end
    #1;
  endtask

  initial begin
    base = '0;
    reset = 1'b1; dec = '0; io_allow_in = 1'b1; aok = 1'b0;
    @(posedge clock); #1;
    drive(1'b1, base, 1'b1, 1'b0); tick();
    drive(1'b0, base, 1'b1, 1'b0);
    check_eq("rst_allow", 32'(ex_allow_in), 32'd1);
    check_eq("rst_req", 32'(req), 32'd0);
    tick();

    // addu 5 + 7
    d = base; d.valid = 1'b1; d.source_register_value = 32'd5; d.multi_use_register_value = 32'd7;
    d.alu_operation = 12'h001; d.register_write = 1'b1; d.write_register = 5'd3;
    drive(1'b0, d, 1'b1, 1'b0); tick();
    // sra 0x80000000 by 4, issued back-to-back behind addu
    d = base; d.valid = 1'b1; d.alu_operation = 12'h400; d.source1_is_shift_amount = 1'b1;
    d.immediate = 16'h0100; d.multi_use_register_value = 32'h8000_0000;
    drive(1'b0, d, 1'b1, 1'b0);
    check_eq("addu_res", io_bus.alu_result, 32'd12);
    check_eq("addu_bp", 32'({bp.valid, bp.data_valid}), 32'b11);
    check_eq("addu_bp_data", bp.write_data, 32'd12);
    tick();
    // slt(-1,1)
    d = base; d.valid = 1'b1; d.source_register_value = 32'hFFFF_FFFF; d.multi_use_register_value = 32'd1;
    d.alu_operation = 12'h004;
    drive(1'b0, d, 1'b1, 1'b0);
    check_eq("sra_res", io_bus.alu_result, 32'hF800_0000);
    tick();
    d.alu_operation = 12'h008;
    drive(1'b0, d, 1'b1, 1'b0);
    check_eq("slt_res", io_bus.alu_result, 32'd1);
    tick();
    // jal at 0x100
    d = base; d.valid = 1'b1; d.program_count = 32'h100; d.source1_is_program_count = 1'b1;
    d.source2_is_8 = 1'b1; d.alu_operation = 12'h001; d.register_write = 1'b1; d.write_register = 5'd31;
    drive(1'b0, d, 1'b1, 1'b0);
    check_eq("sltu_res", io_bus.alu_result, 32'd0);
    tick();
    // addu to $0
    d = base; d.valid = 1'b1; d.alu_operation = 12'h001; d.register_write = 1'b1; d.source_register_value = 32'd9;
    drive(1'b0, d, 1'b1, 1'b0);
    check_eq("jal_res", io_bus.alu_result, 32'h108);
    check_eq("jal_wreg", 32'(io_bus.write_register), 32'd31);
    tick();
    drive(1'b0, base, 1'b1, 1'b0);
    check_eq("r0_bp_valid", 32'(bp.valid), 32'd0);
    tick();

    // lw with address_ok withheld for 3 cycles
    d = base; d.valid = 1'b1; d.is_load_operation = 1'b1; d.alu_operation = 12'h001;
    d.source_register_value = 32'h1000; d.source2_is_immediate = 1'b1; d.immediate = 16'd4;
    d.register_write = 1'b1; d.write_register = 5'd7;
    drive(1'b0, d, 1'b1, 1'b0); tick();
    for (int unsigned i = 0; i < 3; i++) begin
      drive(1'b0, d, 1'b1, 1'b0);
      check_eq("lw_wait_req", 32'(req), 32'd1);
      check_eq("lw_wait_valid", 32'(io_bus.valid), 32'd0);
      check_eq("lw_wait_allow", 32'(ex_allow_in), 32'd0);
      check_eq("lw_wait_dv", 32'(bp.data_valid), 32'd0);
      tick();
    end
    drive(1'b0, base, 1'b1, 1'b1);
    check_eq("lw_acc_valid", 32'(io_bus.valid), 32'd1);
    check_eq("lw_addr", addr, 32'h1004);
    tick();
    drive(1'b0, base, 1'b1, 1'b0);
    check_eq("lw_no_reissue", 32'(req), 32'd0);
    tick();

    // sw accepted, then IO stalls two more cycles
    d = base; d.valid = 1'b1; d.memory_write = 1'b1; d.alu_operation = 12'h001;
    d.source_register_value = 32'h2000; d.source2_is_immediate = 1'b1; d.immediate = 16'd8;
    d.multi_use_register_value = 32'hDEAD_BEEF;
    drive(1'b0, d, 1'b1, 1'b0); tick();
    drive(1'b0, base, 1'b0, 1'b1);
    check_eq("sw_be", 32'(be), 32'hF);
    tick();
    for (int unsigned i = 0; i < 2; i++) begin
      drive(1'b0, base, 1'b0, 1'b1);
      check_eq("sw_stall_req", 32'(req), 32'd0);
      check_eq("sw_stall_addr", addr, 32'h2008);
      check_eq("sw_stall_wdata", wdata, 32'hDEAD_BEEF);
      tick();
    end
    drive(1'b0, base, 1'b1, 1'b0); tick();

    // reset during a pending lw
    d = base; d.valid = 1'b1; d.is_load_operation = 1'b1; d.alu_operation = 12'h001;
    drive(1'b0, d, 1'b1, 1'b0); tick();
    drive(1'b0, base, 1'b1, 1'b0); tick();
    drive(1'b1, base, 1'b1, 1'b0); tick();
    drive(1'b0, base, 1'b1, 1'b0);
    check_eq("rst_mid_req", 32'(req), 32'd0);
    check_eq("rst_mid_valid", 32'(io_bus.valid), 32'd0);
    check_eq("rst_mid_allow", 32'(ex_allow_in), 32'd1);
    tick();

    for (int unsigned n = 0; n < 1500; n++) begin
      d = rand_dec();
      drive($urandom_range(99) == 0, d, $urandom_range(9) < 7, 1'($urandom_range(1)));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
